// File: rtl/shared_reg_arb_pkg.sv
// shared_reg_arb_pkg: shared types and constants for the shared register arbiter.
//   state_t       : arbiter FSM states (IDLE, OWN)
//   *_DEFAULT     : default parameter values
//   ptr_width()   : width of a requester index / rotating pointer
package shared_reg_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    localparam int unsigned NREQ_DEFAULT     = 4;
    localparam int unsigned W_DEFAULT        = 5;
    localparam int unsigned MAX_HOLD_DEFAULT = 8;

    // Index width for n requesters; never below one bit.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority picker.
//   req    : per-requester request vector
//   ptr    : index that has highest priority this cycle
//   winner : one-hot first requester found searching ptr, ptr+1, ... mod NREQ
//   any    : at least one request present
module rr_pick
    import shared_reg_arb_pkg::*;
#(
    parameter  int unsigned NREQ = NREQ_DEFAULT,
    localparam int unsigned PW   = ptr_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] winner,
    output logic            any
);

    logic [PW-1:0] idx;

    // Walk the ring starting at ptr; the first hit wins.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = PW'((32'(ptr) + k) % NREQ);
            if (!any && req[idx]) begin
                winner[idx] = 1'b1;
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin owner arbitration and load sequencing for one
// shared W-bit register, with locked multi-cycle ownership and a hold timeout.
//   clk, rst_n : clock, asynchronous active-low reset
//   cen        : clock enable; low freezes FSM, pointer, hold counter and vec
//   clr        : synchronous clear, effective regardless of cen
//   req, lock  : per-requester request / hold-ownership request
//   wdata      : requester i data at bits [i*W +: W]
//   gnt, busy  : registered one-hot grant, busy == |gnt
//   timeout    : one-cycle pulse on forced release after MAX_HOLD cycles
//   vec        : shared register contents
//   vec_shadow : negedge copy of vec when SHARED_REG_ARB_SHADOW_EN is defined,
//                otherwise tied to zero
module shared_reg_arbiter
    import shared_reg_arb_pkg::*;
#(
    parameter int unsigned NREQ     = NREQ_DEFAULT,
    parameter int unsigned W        = W_DEFAULT,
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cen,
    input  logic              clr,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   lock,
    input  logic [NREQ*W-1:0] wdata,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic              timeout,
    output logic [W-1:0]      vec,
    output logic [W-1:0]      vec_shadow
);

    localparam int unsigned PW = ptr_width(NREQ);
    localparam int unsigned HW = $clog2(MAX_HOLD + 1);

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] owner;
    logic [HW-1:0] hcnt;
    logic [NREQ-1:0] pick;
    logic          pick_any;
    logic [PW-1:0] win_idx;
    logic          keep;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (pick),
        .any    (pick_any)
    );

    // One-hot winner to index.
    always_comb begin
        win_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick[i]) win_idx = PW'(i);
        end
    end

    assign keep = req[owner] && lock[owner];

    // Arbiter FSM with registered grant, busy, timeout and shared register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            owner   <= '0;
            hcnt    <= '0;
            gnt     <= '0;
            busy    <= 1'b0;
            timeout <= 1'b0;
            vec     <= '0;
        end else begin
            timeout <= 1'b0;
            if (clr) begin
                state <= IDLE;
                hcnt  <= '0;
                gnt   <= '0;
                busy  <= 1'b0;
                vec   <= '0;
            end else if (cen) begin
                case (state)
                    IDLE: begin
                        if (pick_any) begin
                            state <= OWN;
                            owner <= win_idx;
                            gnt   <= pick;
                            busy  <= 1'b1;
                            hcnt  <= HW'(1);
                            vec   <= wdata[32'(win_idx) * W +: W];
                        end
                    end
                    OWN: begin
                        if (keep && (hcnt < HW'(MAX_HOLD))) begin
                            hcnt <= hcnt + HW'(1);
                            vec  <= wdata[32'(owner) * W +: W];
                        end else begin
                            // Voluntary or forced release; priority moves past the owner.
                            state   <= IDLE;
                            gnt     <= '0;
                            busy    <= 1'b0;
                            hcnt    <= '0;
                            ptr     <= (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);
                            timeout <= keep;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef SHARED_REG_ARB_SHADOW_EN
    logic cen_q;

    // Remember whether the last posedge was enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cen_q <= 1'b0;
        else        cen_q <= cen;
    end

    // Half-cycle-late copy of vec.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n)     vec_shadow <= '0;
        else if (cen_q) vec_shadow <= vec;
    end
`else
    assign vec_shadow = '0;
`endif

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb_shared_reg_arbiter: directed and randomized checks of shared_reg_arbiter
// against a cycle-level behavioural model of the arbitration rules.
module tb_shared_reg_arbiter;

    localparam int unsigned NREQ     = 4;
    localparam int unsigned W        = 5;
    localparam int unsigned MAX_HOLD = 8;
    localparam int unsigned BW       = NREQ + 2 + 2 * W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cen;
    logic              clr;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   lock;
    logic [NREQ*W-1:0] wdata;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic              timeout;
    logic [W-1:0]      vec;
    logic [W-1:0]      vec_shadow;

    int tests_run = 0;
    int fails     = 0;

    // Behavioural model state: owner index (-1 = nobody), priority pointer, hold count.
    int           m_owner;
    int           m_ptr;
    int           m_hcnt;
    logic [W-1:0] m_vec;
    logic [W-1:0] m_shadow;
    logic         m_timeout;
    logic         m_cenq;

    shared_reg_arbiter #(.NREQ(NREQ), .W(W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cen        (cen),
        .clr        (clr),
        .req        (req),
        .lock       (lock),
        .wdata      (wdata),
        .gnt        (gnt),
        .busy       (busy),
        .timeout    (timeout),
        .vec        (vec),
        .vec_shadow (vec_shadow)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_owner   = -1;
        m_ptr     = 0;
        m_hcnt    = 0;
        m_vec     = '0;
        m_shadow  = '0;
        m_timeout = 1'b0;
        m_cenq    = 1'b0;
    endtask

    // Advance the model by one posedge using the currently driven inputs.
    task automatic model_step();
        int i;
        m_timeout = 1'b0;
        if (m_cenq) m_shadow = m_vec;
        m_cenq = cen;
        if (clr) begin
            m_owner = -1;
            m_hcnt  = 0;
            m_vec   = '0;
        end else if (cen) begin
            if (m_owner < 0) begin
                for (int k = 0; k < NREQ; k++) begin
                    i = (m_ptr + k) % NREQ;
                    if (req[i]) begin
                        m_owner = i;
                        m_vec   = wdata[i*W +: W];
                        m_hcnt  = 1;
                        break;
                    end
                end
            end else if (req[m_owner] && lock[m_owner] && m_hcnt < MAX_HOLD) begin
                m_vec  = wdata[m_owner*W +: W];
                m_hcnt = m_hcnt + 1;
            end else begin
                m_timeout = req[m_owner] && lock[m_owner];
                m_ptr     = (m_owner + 1) % NREQ;
                m_owner   = -1;
            end
        end
    endtask

    function automatic logic [W-1:0] exp_shadow();
`ifdef SHARED_REG_ARB_SHADOW_EN
        return m_shadow;
`else
        return '0;
`endif
    endfunction

    function automatic logic [BW-1:0] exp_bundle();
        logic [NREQ-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return {g, m_owner >= 0, m_timeout, m_vec, exp_shadow()};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
    endtask

    task automatic release_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic reset_dut();
        cen   = 1'b1;
        clr   = 1'b0;
        req   = '0;
        lock  = '0;
        wdata = '0;
        assert_reset();
        release_reset();
    endtask

    task automatic test_reset();
        reset_dut();
        assert_reset();
        tests_run++;
        if ({gnt, busy, timeout, vec, vec_shadow} !== '0) begin
            fails++;
            $display("FAIL reset_state: got gnt=%b busy=%b to=%b vec=%b sh=%b, want all zero",
                     gnt, busy, timeout, vec, vec_shadow);
        end
        release_reset();
        for (int c = 0; c < 3; c++) begin
            tick();
            tests_run++;
            if (gnt !== '0 || vec !== '0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL idle_hold c%0d: got gnt=%b vec=%b busy=%b, want 0000/00000/0",
                         c, gnt, vec, busy);
            end
        end
        // Reset in the middle of a locked ownership.
        req = 4'b0001; lock = 4'b0001; wdata = {NREQ*W{1'b1}};
        tick();
        tick();
        assert_reset();
        tests_run++;
        if (gnt !== '0 || timeout !== 1'b0 || busy !== 1'b0 || vec !== '0) begin
            fails++;
            $display("FAIL reset_mid_own: got gnt=%b to=%b busy=%b vec=%b, want 0000/0/0/00000",
                     gnt, timeout, busy, vec);
        end
        release_reset();
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] rr_gnt [9];
        logic [W-1:0]    rr_vec [9];
        rr_gnt = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
        rr_vec = '{5'd1, 5'd1, 5'd2, 5'd2, 5'd3, 5'd3, 5'd4, 5'd4, 5'd1};
        reset_dut();
        req = '1; lock = '0;
        for (int i = 0; i < NREQ; i++) wdata[i*W +: W] = W'(i + 1);
        for (int c = 0; c < 9; c++) begin
            tick();
            tests_run++;
            if (gnt !== rr_gnt[c] || vec !== rr_vec[c] ||
                {gnt, busy, timeout, vec, vec_shadow} !== exp_bundle()) begin
                fails++;
                $display("FAIL round_robin c%0d: got gnt=%b vec=%b busy=%b, want gnt=%b vec=%b busy=%b",
                         c, gnt, vec, busy, rr_gnt[c], rr_vec[c], rr_gnt[c] != 0);
            end
        end
    endtask

    task automatic test_lock_timeout();
        reset_dut();
        req = 4'b0100; lock = 4'b0100;
        for (int c = 0; c < MAX_HOLD; c++) begin
            wdata = NREQ*W'($urandom);
            tick();
            tests_run++;
            if (gnt !== 4'b0100 || timeout !== 1'b0 || vec !== wdata[2*W +: W]) begin
                fails++;
                $display("FAIL lock_hold c%0d: got gnt=%b to=%b vec=%b, want gnt=0100 to=0 vec=%b",
                         c, gnt, timeout, vec, wdata[2*W +: W]);
            end
        end
        tick();
        tests_run++;
        if (gnt !== 4'b0000 || timeout !== 1'b1) begin
            fails++;
            $display("FAIL lock_timeout: got gnt=%b to=%b, want gnt=0000 to=1", gnt, timeout);
        end
        req = '1; lock = '0;
        tick();
        tests_run++;
        if (gnt !== 4'b1000 || timeout !== 1'b0) begin
            fails++;
            $display("FAIL after_timeout: got gnt=%b to=%b, want gnt=1000 to=0", gnt, timeout);
        end
    endtask

    task automatic test_freeze();
        logic [W-1:0] held;
        int           high;
        reset_dut();
        req = 4'b0001; lock = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            wdata = NREQ*W'($urandom);
            tick();
        end
        held = vec;
        cen  = 1'b0;
        for (int c = 0; c < 4; c++) begin
            wdata = NREQ*W'($urandom);
            tick();
            tests_run++;
            if (gnt !== 4'b0001 || busy !== 1'b1 || vec !== held) begin
                fails++;
                $display("FAIL freeze c%0d: got gnt=%b busy=%b vec=%b, want gnt=0001 busy=1 vec=%b",
                         c, gnt, busy, vec, held);
            end
        end
        cen  = 1'b1;
        high = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (gnt == 4'b0001) high++;
            else break;
        end
        // Count resumed from 3: edges taking it to 4..8 keep the grant, the next releases.
        tests_run++;
        if (high != 5 || timeout !== 1'b1) begin
            fails++;
            $display("FAIL freeze_resume: got %0d more held cycles to=%b, want 5 to=1", high, timeout);
        end
    endtask

    task automatic test_clear();
        reset_dut();
        req = 4'b0001; lock = '0;
        tick();
        req = '0;
        tick();
        req = 4'b0010; clr = 1'b1;
        wdata[1*W +: W] = 5'b11111;
        tick();
        tests_run++;
        if (gnt !== '0 || vec !== '0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL clear_priority: got gnt=%b vec=%b busy=%b, want 0000/00000/0", gnt, vec, busy);
        end
        clr = 1'b0; req = '1;
        tick();
        tests_run++;
        if (gnt !== 4'b0010 || vec !== 5'b11111) begin
            fails++;
            $display("FAIL clear_ptr_kept: got gnt=%b vec=%b, want gnt=0010 vec=11111", gnt, vec);
        end
    endtask

    task automatic test_shadow();
        logic [W-1:0] want;
        reset_dut();
        req = 4'b0001; lock = '0;
        wdata[0 +: W] = 5'b10101;
        tick();
        tests_run++;
        if (vec !== 5'b10101 || vec_shadow !== 5'b00000) begin
            fails++;
            $display("FAIL shadow_pre: got vec=%b sh=%b, want vec=10101 sh=00000", vec, vec_shadow);
        end
        @(negedge clk);
        #1;
`ifdef SHARED_REG_ARB_SHADOW_EN
        want = 5'b10101;
`else
        want = 5'b00000;
`endif
        tests_run++;
        if (vec_shadow !== want) begin
            fails++;
            $display("FAIL shadow_post: got sh=%b, want %b", vec_shadow, want);
        end
    endtask

    task automatic test_random();
        reset_dut();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 9) < 3) begin
                req  = NREQ'($urandom);
                lock = NREQ'($urandom);
            end
            cen   = ($urandom_range(0, 9) != 0);
            clr   = ($urandom_range(0, 29) == 0);
            wdata = NREQ*W'($urandom);
            tick();
            tests_run++;
            if ({gnt, busy, timeout, vec, vec_shadow} !== exp_bundle()) begin
                fails++;
                $display("FAIL random c%0d: got {gnt,busy,to,vec,sh}=%b, want %b",
                         c, {gnt, busy, timeout, vec, vec_shadow}, exp_bundle());
            end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        cen   = 1'b1;
        clr   = 1'b0;
        req   = '0;
        lock  = '0;
        wdata = '0;
        model_reset();
        #1;
        test_reset();
        test_round_robin();
        test_lock_timeout();
        test_freeze();
        test_clear();
        test_shadow();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
